rs232_loader: RTL and testbench



---
 rtl/rs232_loader.sv | 176 +++++++++++++++++
 tb/tb_rs232_loader.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs232_loader.sv
// rs232_loader: serial boot loader that masters an rs232port register
// interface. It hunts for a SYNC byte, reads LEN, writes LEN payload bytes
// into program memory, checks the modulo-256 sum against CHK, and writes an
// ACK or NAK byte back through the port's transmit register.
module rs232_loader #(
  parameter logic [7:0] PORT_BASE = 8'h00,
  parameter int         MEM_AW    = 8,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter logic [7:0] ACK_BYTE  = 8'h06,
  parameter logic [7:0] NAK_BYTE  = 8'h15,
  parameter int         GAP       = 2
) (
  input  logic              cpu_clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [7:0]        outbus_addr,
  output logic [7:0]        outbus_data,
  output logic              outbus_we,
  output logic [7:0]        inbus_addr,
  input  logic [7:0]        inbus_data,
  output logic              inbus_re,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_we,
  output logic [7:0]        byte_count
);

  // Port register map relative to PORT_BASE.
  localparam logic [7:0] TX_DATA  = PORT_BASE;
  localparam logic [7:0] TX_STAT  = PORT_BASE + 8'd1;
  localparam logic [7:0] RX_DATA  = PORT_BASE + 8'd2;
  localparam logic [7:0] RX_STAT  = PORT_BASE + 8'd3;
  localparam logic [7:0] GAP_LAST = 8'(GAP - 1);

  typedef enum logic [3:0] {
    ST_IDLE, ST_RX_POLL, ST_RX_PWAIT, ST_RX_READ, ST_RX_RWAIT, ST_RX_GAP,
    ST_TX_POLL, ST_TX_PWAIT, ST_TX_WRITE
  } state_t;

  typedef enum logic [1:0] {PH_HUNT, PH_LEN, PH_DATA, PH_CHK} phase_t;

  state_t     state;
  phase_t     phase;
  logic [7:0] sum;
  logic [7:0] len;
  logic [7:0] gap_cnt;
  logic       rx_last;

  // Running frame checksum wraps naturally at 8 bits.
  function automatic logic [7:0] add_mod256(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

  // Loader FSM; every strobe is registered so it lines up with the state it
  // belongs to (the read strobe is raised on entry to a POLL/READ state).
  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      phase       <= PH_HUNT;
      sum         <= 8'd0;
      byte_count  <= 8'd0;
      gap_cnt     <= 8'd0;
      rx_last     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      outbus_addr <= 8'd0;
      outbus_data <= 8'd0;
      outbus_we   <= 1'b0;
      inbus_addr  <= 8'd0;
      inbus_re    <= 1'b0;
      mem_addr    <= '0;
      mem_data    <= 8'd0;
      mem_we      <= 1'b0;
    end else begin
      inbus_re  <= 1'b0;
      outbus_we <= 1'b0;
      mem_we    <= 1'b0;
      done      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy       <= 1'b1;
            error      <= 1'b0;
            sum        <= 8'd0;
            byte_count <= 8'd0;
            phase      <= PH_HUNT;
            inbus_re   <= 1'b1;
            inbus_addr <= RX_STAT;
            state      <= ST_RX_POLL;
          end
        end
        ST_RX_POLL: state <= ST_RX_PWAIT;
        ST_RX_PWAIT: begin
          inbus_re <= 1'b1;
          if (inbus_data[0]) begin
            inbus_addr <= RX_DATA;
            state      <= ST_RX_READ;
          end else begin
            inbus_addr <= RX_STAT;
            state      <= ST_RX_POLL;
          end
        end
        ST_RX_READ: state <= ST_RX_RWAIT;
        ST_RX_RWAIT: begin
          // The captured byte is dispatched here so the payload write lands
          // in the first cycle after capture, overlapping the gap wait.
          case (phase)
            PH_HUNT: if (inbus_data == SYNC_BYTE) phase <= PH_LEN;
            PH_LEN: begin
              len   <= inbus_data;
              sum   <= add_mod256(sum, inbus_data);
              phase <= (inbus_data == 8'd0) ? PH_CHK : PH_DATA;
            end
            PH_DATA: begin
              mem_we     <= 1'b1;
              mem_addr   <= MEM_AW'(byte_count);
              mem_data   <= inbus_data;
              byte_count <= byte_count + 8'd1;
              sum        <= add_mod256(sum, inbus_data);
              if (byte_count + 8'd1 == len) phase <= PH_CHK;
            end
            PH_CHK: begin
              sum   <= add_mod256(sum, inbus_data);
              phase <= PH_HUNT;
            end
            default: phase <= PH_HUNT;
          endcase
          rx_last <= (phase == PH_CHK);
          if (GAP == 0) begin
            inbus_re   <= 1'b1;
            inbus_addr <= (phase == PH_CHK) ? TX_STAT : RX_STAT;
            state      <= (phase == PH_CHK) ? ST_TX_POLL : ST_RX_POLL;
          end else begin
            gap_cnt <= 8'd0;
            state   <= ST_RX_GAP;
          end
        end
        ST_RX_GAP: begin
          // Idle cycles let the port's FIFO pop and empty flag settle.
          if (gap_cnt == GAP_LAST) begin
            inbus_re   <= 1'b1;
            inbus_addr <= rx_last ? TX_STAT : RX_STAT;
            state      <= rx_last ? ST_TX_POLL : ST_RX_POLL;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        ST_TX_POLL: state <= ST_TX_PWAIT;
        ST_TX_PWAIT: begin
          if (inbus_data[1]) begin
            inbus_re   <= 1'b1;
            inbus_addr <= TX_STAT;
            state      <= ST_TX_POLL;
          end else begin
            outbus_we   <= 1'b1;
            outbus_addr <= TX_DATA;
            outbus_data <= (sum == 8'd0) ? ACK_BYTE : NAK_BYTE;
            error       <= (sum != 8'd0);
            state       <= ST_TX_WRITE;
          end
        end
        ST_TX_WRITE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rs232_loader.sv
// Bench for rs232_loader: a behavioural rs232port register model feeds two
// loaders (8-bit and 2-bit memory address), a scoreboard holds the expected
// memory writes, replies and completion status, and a monitor checks them.
module tb_rs232_loader;
  localparam logic [7:0] BASE = 8'h00;

  logic       cpu_clk = 1'b0;
  logic       reset, start;
  logic [7:0] inbus_data = 8'h00;

  logic       busy, done, error, outbus_we, inbus_re, mem_we;
  logic [7:0] outbus_addr, outbus_data, inbus_addr, mem_addr, mem_data, byte_count;
  logic       w_busy, w_done, w_error, w_outbus_we, w_inbus_re, w_mem_we;
  logic [7:0] w_outbus_addr, w_outbus_data, w_inbus_addr, w_mem_data, w_byte_count;
  logic [1:0] w_mem_addr;

  rs232_loader #(.PORT_BASE(BASE), .MEM_AW(8)) dut (
    .cpu_clk(cpu_clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .error(error), .outbus_addr(outbus_addr), .outbus_data(outbus_data),
    .outbus_we(outbus_we), .inbus_addr(inbus_addr), .inbus_data(inbus_data),
    .inbus_re(inbus_re), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_we(mem_we), .byte_count(byte_count));

  rs232_loader #(.PORT_BASE(BASE), .MEM_AW(2)) dut_w (
    .cpu_clk(cpu_clk), .reset(reset), .start(start), .busy(w_busy), .done(w_done),
    .error(w_error), .outbus_addr(w_outbus_addr), .outbus_data(w_outbus_data),
    .outbus_we(w_outbus_we), .inbus_addr(w_inbus_addr), .inbus_data(inbus_data),
    .inbus_re(w_inbus_re), .mem_addr(w_mem_addr), .mem_data(w_mem_data),
    .mem_we(w_mem_we), .byte_count(w_byte_count));

  always #5 cpu_clk = ~cpu_clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cyc = 0;
  int mem_seen = 0;

  always @(posedge cpu_clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Port model: registers answer on the negedge of the strobe cycle, so the
  // loader sees them throughout the following cycle.
  logic [7:0] rxq[$];
  int   rx_hold = 0;
  int   tx_hold = 0;
  logic last_rx_ready = 1'b0;

  always @(negedge cpu_clk) begin
    if (inbus_re) begin
      if (inbus_addr == BASE + 8'd3) begin
        if (rx_hold > 0) begin
          rx_hold--;
          last_rx_ready = 1'b0;
        end else begin
          last_rx_ready = (rxq.size() > 0);
        end
        inbus_data = {7'd0, last_rx_ready};
      end else if (inbus_addr == BASE + 8'd2) begin
        check("data read only after ready status", last_rx_ready, 1);
        inbus_data = (rxq.size() > 0) ? rxq.pop_front() : 8'hEE;
        last_rx_ready = 1'b0;
      end else if (inbus_addr == BASE + 8'd1) begin
        if (tx_hold > 0) begin
          tx_hold--;
          inbus_data = 8'h02;
        end else begin
          inbus_data = 8'h00;
        end
      end else begin
        inbus_data = 8'h00;
      end
    end
  end

  // Scoreboard queues.
  typedef struct { logic [7:0] a; logic [7:0] d; } mem_t;
  mem_t       exp_mem[$];
  logic [7:0] exp_tx[$];
  int         exp_tx_cyc[$];
  logic [8:0] exp_done[$];

  // Monitor: pops and compares whenever the loader presents a strobe.
  always @(negedge cpu_clk) begin
    if (mem_we) begin
      mem_seen++;
      if (exp_mem.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected mem_we: got addr=%0h data=%0h, required no write", mem_addr, mem_data);
      end else begin
        mem_t e;
        e = exp_mem.pop_front();
        check("mem_addr", mem_addr, e.a);
        check("mem_data", mem_data, e.d);
        check("wrap mem_we", w_mem_we, 1);
        check("wrap mem_addr", w_mem_addr, e.a & 8'h03);
        check("wrap mem_data", w_mem_data, e.d);
      end
    end
    if (outbus_we) begin
      if (exp_tx.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected outbus_we: got data=%0h, required no write", outbus_data);
      end else begin
        logic [7:0] b;
        int c;
        b = exp_tx.pop_front();
        c = exp_tx_cyc.pop_front();
        check("reply addr", outbus_addr, BASE);
        check("reply byte", outbus_data, b);
        check("wrap reply byte", w_outbus_data, b);
        if (c >= 0) check("reply cycle after start", cyc - start_cyc, c);
      end
    end
    if (done) begin
      if (exp_done.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected done: got 1, required 0");
      end else begin
        logic [8:0] e;
        e = exp_done.pop_front();
        check("error at done", error, e[8]);
        check("byte_count at done", byte_count, e[7:0]);
        check("busy low with done", busy, 0);
        check("wrap done", w_done, 1);
        check("wrap error", w_error, e[8]);
        check("wrap byte_count", w_byte_count, e[7:0]);
      end
    end
    if (inbus_re || outbus_we) check("read/write strobe exclusive", inbus_re & outbus_we, 0);
  end

  task automatic check_zero(input string tag);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " error"}, error, 0);
    check({tag, " strobes"}, {outbus_we, inbus_re, mem_we}, 0);
    check({tag, " byte_count"}, byte_count, 0);
    check({tag, " buses"}, {outbus_addr, outbus_data, inbus_addr, mem_data}, 0);
    check({tag, " mem_addr"}, mem_addr, 0);
    check({tag, " wrap mem_addr"}, w_mem_addr, 0);
  endtask

  task automatic pulse_start();
    @(negedge cpu_clk);
    start = 1'b1;
    start_cyc = cyc;
    @(negedge cpu_clk);
    start = 1'b0;
    check("busy after start", busy, 1);
    check("status read after start", inbus_re, 1);
    check("status addr after start", inbus_addr, BASE + 8'd3);
    check("wrap status read after start", {w_busy, w_inbus_re, w_inbus_addr}, {2'b11, BASE + 8'd3});
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge cpu_clk);
      n++;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL done timeout: got no done in %0d cycles, required done", budget);
      @(negedge cpu_clk); reset = 1'b1;
      @(negedge cpu_clk); reset = 1'b0;
      exp_mem.delete(); exp_tx.delete(); exp_tx_cyc.delete(); exp_done.delete(); rxq.delete();
    end else begin
      @(negedge cpu_clk);
      check("mem writes outstanding", exp_mem.size(), 0);
      check("replies outstanding", exp_tx.size(), 0);
      check("done outstanding", exp_done.size(), 0);
    end
  endtask

  task automatic good_frame();
    rxq.push_back(8'hA5); rxq.push_back(8'h03); rxq.push_back(8'h11);
    rxq.push_back(8'h22); rxq.push_back(8'h33); rxq.push_back(8'h97);
    exp_mem.push_back('{8'h00, 8'h11});
    exp_mem.push_back('{8'h01, 8'h22});
    exp_mem.push_back('{8'h02, 8'h33});
    exp_tx.push_back(8'h06); exp_tx_cyc.push_back(39);
    exp_done.push_back({1'b0, 8'd3});
    pulse_start();
    wait_done(200);
  endtask

  initial begin
    int s;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge cpu_clk);
    check_zero("reset");
    reset = 1'b0;

    // Good frame: 03+11+22+33+97 = 0x100.
    good_frame();
    check("byte_count held after done", byte_count, 3);

    // Bad checksum: 02+01+02+00 = 05 -> NAK.
    rxq.push_back(8'hA5); rxq.push_back(8'h02); rxq.push_back(8'h01);
    rxq.push_back(8'h02); rxq.push_back(8'h00);
    exp_mem.push_back('{8'h00, 8'h01});
    exp_mem.push_back('{8'h01, 8'h02});
    exp_tx.push_back(8'h15); exp_tx_cyc.push_back(33);
    exp_done.push_back({1'b1, 8'd2});
    pulse_start();
    wait_done(200);
    check("error held after NAK", error, 1);

    // Good frame with SYNC as payload clears error: 01+A5+5A = 0x100.
    rxq.push_back(8'hA5); rxq.push_back(8'h01); rxq.push_back(8'hA5); rxq.push_back(8'h5A);
    exp_mem.push_back('{8'h00, 8'hA5});
    exp_tx.push_back(8'h06); exp_tx_cyc.push_back(27);
    exp_done.push_back({1'b0, 8'd1});
    pulse_start();
    check("error cleared on start", error, 0);
    wait_done(200);

    // Leading garbage and zero length.
    rxq.push_back(8'h00); rxq.push_back(8'hFF); rxq.push_back(8'h5A);
    rxq.push_back(8'hA5); rxq.push_back(8'h00); rxq.push_back(8'h00);
    exp_tx.push_back(8'h06); exp_tx_cyc.push_back(39);
    exp_done.push_back({1'b0, 8'd0});
    pulse_start();
    wait_done(200);

    // Backpressure: 20 not-ready polls (+40) and 10 tx-full polls (+20).
    rx_hold = 20;
    tx_hold = 10;
    rxq.push_back(8'hA5); rxq.push_back(8'h00); rxq.push_back(8'h00);
    exp_tx.push_back(8'h06); exp_tx_cyc.push_back(81);
    exp_done.push_back({1'b0, 8'd0});
    pulse_start();
    wait_done(300);
    check("rx not-ready polls consumed", rx_hold, 0);
    check("tx full polls consumed", tx_hold, 0);

    // Reset after the second payload byte.
    mem_seen = 0;
    rxq.push_back(8'hA5); rxq.push_back(8'h04); rxq.push_back(8'h01);
    rxq.push_back(8'h02); rxq.push_back(8'h03); rxq.push_back(8'h04); rxq.push_back(8'hF2);
    exp_mem.push_back('{8'h00, 8'h01});
    exp_mem.push_back('{8'h01, 8'h02});
    pulse_start();
    s = 0;
    while (mem_seen < 2 && s < 200) begin
      @(negedge cpu_clk);
      s++;
    end
    check("second payload write seen", mem_seen, 2);
    reset = 1'b1;
    @(negedge cpu_clk);
    check_zero("mid-frame reset");
    reset = 1'b0;
    s = 0;
    repeat (30) begin
      @(negedge cpu_clk);
      s += int'(mem_we) + int'(outbus_we) + int'(inbus_re) + int'(busy);
    end
    check("activity after reset", s, 0);
    check("mem writes outstanding after reset", exp_mem.size(), 0);
    rxq.delete();
    last_rx_ready = 1'b0;
    good_frame();

    // Wrap on the 2-bit instance plus an ignored mid-frame start.
    // 06+10+11+12+13+14+15 = 0x75, CHK = 0x8B.
    mem_seen = 0;
    rxq.push_back(8'hA5); rxq.push_back(8'h06);
    for (int i = 0; i < 6; i++) begin
      rxq.push_back(8'h10 + 8'(i));
      exp_mem.push_back('{8'(i), 8'h10 + 8'(i)});
    end
    rxq.push_back(8'h8B);
    exp_tx.push_back(8'h06); exp_tx_cyc.push_back(57);
    exp_done.push_back({1'b0, 8'd6});
    pulse_start();
    s = 0;
    while (mem_seen < 3 && s < 200) begin
      @(negedge cpu_clk);
      s++;
    end
    @(negedge cpu_clk);
    start = 1'b1;
    @(negedge cpu_clk);
    start = 1'b0;
    check("busy through ignored start", busy, 1);
    wait_done(300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, required finish");
    $fatal(1, "watchdog");
  end

endmodule
